amm_read_cmd_gen: RTL and testbench

//  Read-command stage directly upstream of the netdma readmaster byte aligner.

---
 rtl/amm_read_cmd_gen.sv | 142 ++++++++++++++
 tb/tb_amm_read_cmd_gen.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/amm_read_cmd_gen.sv
// Word-aligned Avalon-MM pipelined read command generator feeding the netdma readmaster byte aligner.
// Optional feature macro: AMM_RD_STALL_STAT_EN adds the stall_cnt_o waitrequest statistics counter.
module amm_read_cmd_gen #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned MAX_PENDING = 8,
    localparam int unsigned BYTES      = DATA_WIDTH / 8,
    localparam int unsigned OFS_W      = $clog2(BYTES)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] desc_addr_i,
    input  logic [LEN_WIDTH-1:0]  desc_len_i,
    input  logic                  desc_valid_i,
    output logic                  desc_ready_o,
    output logic [ADDR_WIDTH-1:0] address_o,
    output logic                  read_o,
    input  logic                  waitrequest_i,
    input  logic                  readdatavalid_i,
    output logic                  run_o,
    output logic [OFS_W-1:0]      offset_o,
    output logic                  busy_o,
`ifdef AMM_RD_STALL_STAT_EN
    output logic [31:0]           stall_cnt_o,
`endif
    output logic                  done_o
);

    localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
    localparam int unsigned CNT_W  = LEN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_nx;
    logic [CNT_W-1:0]  reads_left;
    logic [CNT_W-1:0]  reads_left_nx;
    logic [CNT_W-1:0]  len_ext;
    logic [CNT_W-1:0]  reads_init;
    logic              acc;
    logic              rsp;

    // A response with nothing outstanding (e.g. left over from before a reset) is dropped.
    assign acc = read_o & ~waitrequest_i;
    assign rsp = readdatavalid_i & (pending != '0);

    always_comb begin
        pending_nx = pending;
        if (acc && !rsp) begin
            pending_nx = pending + PEND_W'(1);
        end else if (!acc && rsp) begin
            pending_nx = pending - PEND_W'(1);
        end
    end

    assign reads_left_nx = acc ? reads_left - CNT_W'(1) : reads_left;

    // ceil(len/BYTES) words plus the one extra word the aligner consumes.
    assign len_ext    = CNT_W'(desc_len_i) + CNT_W'(BYTES - 1);
    assign reads_init = (len_ext >> OFS_W) + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            desc_ready_o <= 1'b0;
            read_o       <= 1'b0;
            run_o        <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            address_o    <= '0;
            offset_o     <= '0;
            reads_left   <= '0;
            pending      <= '0;
        end else begin
            pending <= pending_nx;
            done_o  <= 1'b0;
            case (state)
                IDLE: begin
                    desc_ready_o <= 1'b1;
                    if (desc_valid_i && desc_ready_o) begin
                        desc_ready_o <= 1'b0;
                        address_o    <= {desc_addr_i[ADDR_WIDTH-1:OFS_W], OFS_W'(0)};
                        offset_o     <= desc_addr_i[OFS_W-1:0];
                        busy_o       <= 1'b1;
                        // Zero-length descriptors pass through DRAIN with run held low.
                        if (desc_len_i == '0) begin
                            state      <= DRAIN;
                            reads_left <= '0;
                        end else begin
                            state      <= ISSUE;
                            reads_left <= reads_init;
                            read_o     <= 1'b1;
                            run_o      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    reads_left <= reads_left_nx;
                    if (acc) begin
                        address_o <= address_o + ADDR_WIDTH'(BYTES);
                    end
                    if (reads_left_nx == '0) begin
                        state  <= DRAIN;
                        read_o <= 1'b0;
                    end else begin
                        read_o <= (pending_nx < PEND_W'(MAX_PENDING));
                    end
                end
                DRAIN: begin
                    // Leaving on the final response gives done_o one cycle after it.
                    if (pending_nx == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                        run_o  <= 1'b0;
                        busy_o <= 1'b0;
                    end
                end
                DONE: begin
                    state        <= IDLE;
                    desc_ready_o <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef AMM_RD_STALL_STAT_EN
    // Saturating count of cycles a read request is held off by waitrequest.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (read_o && waitrequest_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_amm_read_cmd_gen.sv
// Self-checking bench for amm_read_cmd_gen: bench-side Avalon slave model plus a read-address scoreboard.
`timescale 1ns/1ps
module tb_amm_read_cmd_gen;

    localparam int MP = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] desc_addr_i = '0;
    logic [15:0] desc_len_i = '0;
    logic        desc_valid_i = 1'b0;
    logic        desc_ready_o;
    logic [31:0] address_o;
    logic        read_o;
    logic        waitrequest_i = 1'b0;
    logic        readdatavalid_i = 1'b0;
    logic        run_o;
    logic [2:0]  offset_o;
    logic        busy_o;
    logic        done_o;
`ifdef AMM_RD_STALL_STAT_EN
    logic [31:0] stall_cnt_o;
`endif

    amm_read_cmd_gen #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (32),
        .LEN_WIDTH  (16),
        .MAX_PENDING(MP)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .desc_addr_i    (desc_addr_i),
        .desc_len_i     (desc_len_i),
        .desc_valid_i   (desc_valid_i),
        .desc_ready_o   (desc_ready_o),
        .address_o      (address_o),
        .read_o         (read_o),
        .waitrequest_i  (waitrequest_i),
        .readdatavalid_i(readdatavalid_i),
        .run_o          (run_o),
        .offset_o       (offset_o),
        .busy_o         (busy_o),
`ifdef AMM_RD_STALL_STAT_EN
        .stall_cnt_o    (stall_cnt_o),
`endif
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          reads_seen = 0;
    int          tb_pending = 0;
    bit          hold_resp = 1'b0;
    bit          stray_rv = 1'b0;
    int          stall_target = -1;
    int          stall_left = 0;
    int          stall_obs = 0;
    int          last_rv_cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          done_cnt = 0;
    bit          run_seen = 1'b0;
    bit          prev_done = 1'b0;
    logic [2:0]  exp_ofs = '0;
    int          base;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    always @(posedge clk_i) cyc++;

    // Slave model and output monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        int pend_before;
        if (rst_i) begin
            readdatavalid_i = 1'b0;
            waitrequest_i   = 1'b0;
            tb_pending      = 0;
            prev_done       = 1'b0;
        end else begin
            if (run_o) run_seen = 1'b1;
            if (desc_valid_i && desc_ready_o) acc_cyc = cyc;
            if (done_o) begin
                done_cyc = cyc;
                done_cnt++;
                chk("done_run_low", 64'(run_o), 64'(0));
                chk("done_busy_low", 64'(busy_o), 64'(0));
                chk("done_offset", 64'(offset_o), 64'(exp_ofs));
                chk("done_single_cycle", 64'(prev_done), 64'(0));
            end
            prev_done = done_o;
            if (read_o) chk("pending_cap", 64'(tb_pending < MP), 64'(1));
            if (read_o && reads_seen == stall_target && stall_left > 0) begin
                waitrequest_i = 1'b1;
                stall_left--;
                stall_obs++;
                if (exp_q.size() != 0) chk("stall_addr_hold", 64'(address_o), 64'(exp_q[0]));
            end else begin
                waitrequest_i = 1'b0;
            end
            pend_before = tb_pending;
            if (read_o && !waitrequest_i) begin
                if (exp_q.size() == 0) chk("unexpected_read", 64'(exp_q.size()), 64'(1));
                else chk("read_addr", 64'(address_o), 64'(exp_q.pop_front()));
                reads_seen++;
                tb_pending++;
            end
            readdatavalid_i = (!hold_resp && pend_before > 0) || stray_rv;
            if (!hold_resp && pend_before > 0) begin
                tb_pending--;
                last_rv_cyc = cyc;
            end
        end
    end

    task automatic send(input logic [31:0] addr, input logic [15:0] len);
        int          n;
        logic [31:0] wbase;
        bit          hs;
        n     = (len == 16'd0) ? 0 : (int'(len) + 7) / 8 + 1;
        wbase = addr & 32'hFFFF_FFF8;
        for (int i = 0; i < n; i++) exp_q.push_back(wbase + 32'(i * 8));
        exp_ofs      = addr[2:0];
        desc_addr_i  = addr;
        desc_len_i   = len;
        desc_valid_i = 1'b1;
        hs = 1'b0;
        for (int k = 0; k < 50 && !hs; k++) begin
            @(negedge clk_i);
            hs = desc_ready_o;
            @(posedge clk_i);
            #1;
        end
        desc_valid_i = 1'b0;
        chk("desc_accepted", 64'(hs), 64'(1));
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_cnt;
        for (int k = 0; k < budget && done_cnt == start; k++) @(posedge clk_i);
        #1;
        chk("done_seen", 64'(done_cnt), 64'(start + 1));
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", 64'(desc_ready_o), 64'(0));
        chk("rst_read", 64'(read_o), 64'(0));
        chk("rst_run", 64'(run_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_addr", 64'(address_o), 64'(0));
        chk("rst_offset", 64'(offset_o), 64'(0));
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        chk("ready_after_release", 64'(desc_ready_o), 64'(1));

        // Unaligned 16-byte descriptor.
        base = reads_seen;
        send(32'h0000_1003, 16'd16);
        chk("A_offset", 64'(offset_o), 64'(3));
        chk("A_run", 64'(run_o), 64'(1));
        chk("A_read_latency", 64'(read_o), 64'(1));
        wait_done(100);
        chk("A_reads", 64'(reads_seen - base), 64'(3));
        chk("A_done_latency", 64'(done_cyc), 64'(last_rv_cyc + 1));
        chk("A_queue_empty", 64'(exp_q.size()), 64'(0));

        // Aligned single word.
        base = reads_seen;
        send(32'h0000_2000, 16'd8);
        chk("B_offset", 64'(offset_o), 64'(0));
        wait_done(100);
        chk("B_reads", 64'(reads_seen - base), 64'(2));
        chk("B_idle_run", 64'(run_o), 64'(0));
        chk("B_idle_ready", 64'(desc_ready_o), 64'(1));

        // Zero length.
        base = reads_seen;
        run_seen = 1'b0;
        send(32'h0000_3005, 16'd0);
        wait_done(20);
        chk("C_reads", 64'(reads_seen - base), 64'(0));
        chk("C_run_never", 64'(run_seen), 64'(0));
        chk("C_done_latency", 64'(done_cyc), 64'(acc_cyc + 2));

        // Outstanding limit with responses withheld.
        base = reads_seen;
        hold_resp = 1'b1;
        send(32'h0000_4000, 16'd40);
        repeat (20) @(posedge clk_i);
        #1;
        chk("D_reads_capped", 64'(reads_seen - base), 64'(2));
        chk("D_read_low", 64'(read_o), 64'(0));
        hold_resp = 1'b0;
        wait_done(200);
        chk("D_reads_total", 64'(reads_seen - base), 64'(6));
        chk("D_done_latency", 64'(done_cyc), 64'(last_rv_cyc + 1));

        // Five waitrequest cycles on the second read.
        base = reads_seen;
        stall_target = reads_seen + 1;
        stall_left = 5;
        stall_obs = 0;
        send(32'h0000_5000, 16'd16);
        wait_done(200);
        stall_target = -1;
        chk("E_stall_cycles", 64'(stall_obs), 64'(5));
        chk("E_reads", 64'(reads_seen - base), 64'(3));
`ifdef AMM_RD_STALL_STAT_EN
        chk("E_stall_cnt", 64'(stall_cnt_o), 64'(5));
`endif

        // Address wrap at the top of the space.
        base = reads_seen;
        send(32'hFFFF_FFF8, 16'd16);
        wait_done(100);
        chk("F_reads", 64'(reads_seen - base), 64'(3));
        chk("F_queue_empty", 64'(exp_q.size()), 64'(0));

        // Reset in the middle of ISSUE.
        hold_resp = 1'b1;
        send(32'h0000_7000, 16'd64);
        chk("G_read_before_rst", 64'(read_o), 64'(1));
        rst_i = 1'b1;
        #1;
        chk("G_read_async", 64'(read_o), 64'(0));
        chk("G_run_async", 64'(run_o), 64'(0));
        chk("G_busy_async", 64'(busy_o), 64'(0));
        exp_q.delete();
        hold_resp = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        chk("G_ready_in_rst", 64'(desc_ready_o), 64'(0));
        @(posedge clk_i);
        #1;
        chk("G_ready_after", 64'(desc_ready_o), 64'(1));

        // Late responses from before the reset must not disturb the next descriptor.
        stray_rv = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        stray_rv = 1'b0;
        base = reads_seen;
        send(32'h0000_6000, 16'd8);
        wait_done(100);
        chk("H_reads", 64'(reads_seen - base), 64'(2));
        chk("H_done_latency", 64'(done_cyc), 64'(last_rv_cyc + 1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
